// File: rtl/mem_pkg.sv
// Shared types and default widths for the mem_burst_master sequencer and its watchdog.
package mem_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_LEN_WIDTH  = DEF_ADDR_WIDTH + 1;
    localparam int unsigned DEF_N_OF_WORDS = 256;
    localparam int unsigned DEF_TIMEOUT    = 64;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } mem_op_e;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        REQ,
        WAIT,
        PUSH,
        DONE
    } burst_state_e;

endpackage

// File: rtl/mem_burst_master_wdog.sv
// Per-word transaction watchdog: loadable down-counter that flags expiry once it reaches zero.
module mem_burst_wdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    // Loaded one short so expiry is seen on the TIMEOUT_CYCLES-th timed cycle.
    localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/mem_burst_master.sv
// Burst sequencer in front of memx: splits one command into single-word mem_rd/mem_wr requests.
module mem_burst_master
    import mem_pkg::*;
#(
    parameter int unsigned RAM_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned RAM_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned RAM_N_OF_WORDS = DEF_N_OF_WORDS,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_op_i,
    input  logic [RAM_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [RAM_ADDR_WIDTH:0]   cmd_len_i,
    input  logic                      wdt_valid_i,
    output logic                      wdt_ready_o,
    input  logic [RAM_DATA_WIDTH-1:0] wdt_data_i,
    output logic                      rdt_valid_o,
    input  logic                      rdt_ready_i,
    output logic [RAM_DATA_WIDTH-1:0] rdt_data_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic                      mem_rd_o,
    output logic                      mem_wr_o,
    output logic [RAM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [RAM_DATA_WIDTH-1:0] mem_wdt_o,
    input  logic                      mem_busy_i,
    input  logic [RAM_DATA_WIDTH-1:0] mem_rdt_i,
    input  logic                      mem_wok_i
);

    localparam int unsigned AW = RAM_ADDR_WIDTH;
    localparam logic [AW:0] N_WORDS = (AW + 1)'(RAM_N_OF_WORDS);
    localparam logic [AW:0] LEN_ONE = (AW + 1)'(1);

    burst_state_e state;
    mem_op_e      op;
    logic [AW:0]  rem;
    logic         wok_seen;
    logic [AW:0]  end_addr;
    logic         range_ok;
    logic         wdog_clr, wdog_load, wdog_en, wdog_expired;

    // addr and len are bounded first so the AW+1-bit sum cannot wrap past N.
    always_comb begin
        end_addr = {1'b0, cmd_addr_i} + cmd_len_i;
        range_ok = ({1'b0, cmd_addr_i} < N_WORDS) && (cmd_len_i <= N_WORDS) && (end_addr <= N_WORDS);
    end

    always_comb begin
        wdog_clr  = (state == DONE);
        wdog_load = (state == IDLE) || (state == FETCH) || (state == PUSH);
        wdog_en   = (state == REQ) || (state == WAIT);
    end

    mem_burst_wdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk_i),
        .rst_n  (rst_n_i),
        .clr    (wdog_clr),
        .load   (wdog_load),
        .en     (wdog_en),
        .expired(wdog_expired)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            op          <= OP_READ;
            rem         <= '0;
            wok_seen    <= 1'b0;
            cmd_ready_o <= 1'b0;
            wdt_ready_o <= 1'b0;
            rdt_valid_o <= 1'b0;
            rdt_data_o  <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            mem_rd_o    <= 1'b0;
            mem_wr_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdt_o   <= '0;
        end else begin
            cmd_ready_o <= 1'b0;
            wdt_ready_o <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready_o <= !(cmd_valid_i && cmd_ready_o);
                    if (cmd_valid_i && cmd_ready_o) begin
                        op         <= cmd_op_i ? OP_WRITE : OP_READ;
                        mem_addr_o <= cmd_addr_i;
                        rem        <= cmd_len_i;
                        if (cmd_len_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else if (!range_ok) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                            err_o  <= 1'b1;
                        end else if (cmd_op_i) begin
                            state <= FETCH;
                        end else begin
                            state    <= REQ;
                            mem_rd_o <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (wdt_valid_i) begin
                        mem_wdt_o   <= wdt_data_i;
                        wdt_ready_o <= 1'b1;
                        mem_wr_o    <= 1'b1;
                        wok_seen    <= 1'b0;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (wdog_expired) begin
                        mem_rd_o <= 1'b0;
                        mem_wr_o <= 1'b0;
                        done_o   <= 1'b1;
                        err_o    <= 1'b1;
                        state    <= DONE;
                    end else if (mem_busy_i) begin
                        mem_rd_o <= 1'b0;
                        mem_wr_o <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (wdog_expired) begin
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                        state  <= DONE;
                    end else if (mem_busy_i) begin
                        if (mem_wok_i) wok_seen <= 1'b1;
                    end else if (op == OP_READ) begin
                        rdt_data_o  <= mem_rdt_i;
                        rdt_valid_o <= 1'b1;
                        state       <= PUSH;
                    end else if (!(wok_seen || mem_wok_i)) begin
                        done_o <= 1'b1;
                        err_o  <= 1'b1;
                        state  <= DONE;
                    end else begin
                        mem_addr_o <= mem_addr_o + 1'b1;
                        rem        <= rem - 1'b1;
                        if (rem != LEN_ONE) begin
                            state <= FETCH;
                        end else begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                PUSH: begin
                    if (rdt_ready_i) begin
                        rdt_valid_o <= 1'b0;
                        mem_addr_o  <= mem_addr_o + 1'b1;
                        rem         <= rem - 1'b1;
                        if (rem != LEN_ONE) begin
                            mem_rd_o <= 1'b1;
                            state    <= REQ;
                        end else begin
                            done_o <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    cmd_ready_o <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_master.sv
// Directed bench for mem_burst_master with a small behavioural memx responder (3-cycle busy).
module tb_mem_burst_master;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 10;
    localparam int unsigned NW = 256;
    localparam int unsigned TO = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          cmd_valid, cmd_ready_o, cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [AW:0]   cmd_len;
    logic          wdt_valid, wdt_ready_o;
    logic [DW-1:0] wdt_data;
    logic          rdt_valid_o, rdt_ready;
    logic [DW-1:0] rdt_data_o;
    logic          done_o, err_o, mem_rd_o, mem_wr_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdt_o, mem_rdt;
    logic          mem_busy, mem_wok;

    mem_burst_master #(
        .RAM_DATA_WIDTH(DW),
        .RAM_ADDR_WIDTH(AW),
        .RAM_N_OF_WORDS(NW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op),
        .cmd_addr_i(cmd_addr), .cmd_len_i(cmd_len),
        .wdt_valid_i(wdt_valid), .wdt_ready_o(wdt_ready_o), .wdt_data_i(wdt_data),
        .rdt_valid_o(rdt_valid_o), .rdt_ready_i(rdt_ready), .rdt_data_o(rdt_data_o),
        .done_o(done_o), .err_o(err_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o), .mem_wdt_o(mem_wdt_o),
        .mem_busy_i(mem_busy), .mem_rdt_i(mem_rdt), .mem_wok_i(mem_wok)
    );

    logic [48:0] outs;
    assign outs = {cmd_ready_o, wdt_ready_o, rdt_valid_o, done_o, err_o, mem_rd_o, mem_wr_o,
                   mem_addr_o, mem_wdt_o, rdt_data_o};

    // memx stand-in: busy for 3 cycles per request, wok/read data on the falling cycle
    logic [DW-1:0] mem_arr [0:1023];
    logic          stuck, no_wok, lat_wr;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdt;
    int unsigned   busy_cnt;

    always @(posedge clk) begin
        if (!rst_n) begin
            mem_busy <= 1'b0;
            mem_wok  <= 1'b0;
            mem_rdt  <= '0;
            busy_cnt <= 0;
        end else begin
            mem_wok <= 1'b0;
            if (stuck) begin
                mem_busy <= 1'b1;
            end else if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) begin
                    mem_busy <= 1'b0;
                    if (lat_wr) begin
                        mem_arr[lat_addr] <= lat_wdt;
                        mem_wok <= !no_wok;
                    end else begin
                        mem_rdt <= mem_arr[lat_addr];
                    end
                end
            end else if (mem_rd_o || mem_wr_o) begin
                mem_busy <= 1'b1;
                busy_cnt <= 3;
                lat_wr   <= mem_wr_o;
                lat_addr <= mem_addr_o;
                lat_wdt  <= mem_wdt_o;
            end else begin
                mem_busy <= 1'b0;
            end
        end
    end

    int unsigned   n_done, n_rd_req, n_wr_req, n_excl;
    logic          prev_rd, prev_wr;
    logic [AW-1:0] req_addr_q [$];
    logic [DW-1:0] req_wdt_q [$];
    logic [DW-1:0] rdq [$];

    initial begin
        n_done = 0; n_rd_req = 0; n_wr_req = 0; n_excl = 0; prev_rd = 1'b0; prev_wr = 1'b0;
    end

    always @(negedge clk) begin
        if (done_o) n_done <= n_done + 1;
        if (mem_rd_o && !prev_rd) begin
            n_rd_req <= n_rd_req + 1;
            req_addr_q.push_back(mem_addr_o);
        end
        if (mem_wr_o && !prev_wr) begin
            n_wr_req <= n_wr_req + 1;
            req_addr_q.push_back(mem_addr_o);
            req_wdt_q.push_back(mem_wdt_o);
        end
        prev_rd <= mem_rd_o;
        prev_wr <= mem_wr_o;
        if (mem_rd_o && mem_wr_o) n_excl <= n_excl + 1;
        if (rdt_valid_o && rdt_ready) rdq.push_back(rdt_data_o);
    end

    int tests = 0;
    int fails = 0;
    logic [DW-1:0] wpat [0:3];

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_cmd(input logic op, input logic [AW-1:0] addr, input logic [AW:0] len,
                            output bit ok);
        cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready_o) begin
                step(1);
                ok = 1'b1;
                break;
            end
            step(1);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic feed(input int unsigned n, output bit ok);
        ok = 1'b1;
        for (int unsigned k = 0; k < n; k++) begin
            bit got = 1'b0;
            wdt_valid = 1'b1;
            wdt_data  = wpat[k];
            for (int i = 0; i < 200; i++) begin
                if (wdt_ready_o) begin
                    got = 1'b1;
                    break;
                end
                step(1);
            end
            if (!got) begin
                ok = 1'b0;
                break;
            end
            step(1);
        end
        wdt_valid = 1'b0;
    endtask

    task automatic wait_done(output bit ok, output logic err);
        ok = 1'b0;
        err = 1'bx;
        for (int i = 0; i < 500; i++) begin
            if (done_o) begin
                ok = 1'b1;
                err = err_o;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(2);
        tests++;
        if (outs !== '0) begin fails++; $display("FAIL reset_outputs: got %h want 0", outs); end
        rst_n = 1'b1;
        step(1);
        tests++;
        if (cmd_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", cmd_ready_o); end
    endtask

    task automatic test_write_burst;
        bit ok, fok, dok;
        logic err;
        int unsigned abase = req_addr_q.size();
        int unsigned wbase = req_wdt_q.size();
        int unsigned w0 = n_wr_req;
        wpat[0] = 16'h1010; wpat[1] = 16'h3030; wpat[2] = 16'h9090;
        send_cmd(1'b1, 10'h000, 11'd3, ok);
        feed(3, fok);
        wait_done(dok, err);
        tests++;
        if ({ok, fok, dok, err} !== 4'b1110) begin
            fails++; $display("FAIL wr_done: got acc/feed/done/err %b%b%b%b want 1110", ok, fok, dok, err);
        end
        tests++;
        if (n_wr_req - w0 !== 3) begin fails++; $display("FAIL wr_count: got %0d want 3", n_wr_req - w0); end
        for (int unsigned k = 0; k < 3; k++) begin
            logic [AW-1:0] a = (abase + k < req_addr_q.size()) ? req_addr_q[abase + k] : 'x;
            logic [DW-1:0] d = (wbase + k < req_wdt_q.size()) ? req_wdt_q[wbase + k] : 'x;
            tests++;
            if (a !== AW'(k) || d !== wpat[k]) begin
                fails++; $display("FAIL wr_word%0d: got addr %h data %h want %h %h", k, a, d, k, wpat[k]);
            end
        end
    endtask

    task automatic test_read_burst;
        bit ok, dok;
        logic err;
        int unsigned rbase = rdq.size();
        rdt_ready = 1'b1;
        send_cmd(1'b0, 10'h000, 11'd3, ok);
        wait_done(dok, err);
        tests++;
        if ({ok, dok, err} !== 3'b110) begin fails++; $display("FAIL rd_done: got %b%b%b want 110", ok, dok, err); end
        for (int unsigned k = 0; k < 3; k++) begin
            logic [DW-1:0] d = (rbase + k < rdq.size()) ? rdq[rbase + k] : 'x;
            tests++;
            if (d !== wpat[k]) begin fails++; $display("FAIL rd_word%0d: got %h want %h", k, d, wpat[k]); end
        end
    endtask

    task automatic test_read_backpressure;
        bit ok, dok, seen = 1'b0, stable = 1'b1;
        logic err;
        int unsigned r0 = n_rd_req;
        int unsigned rbase = rdq.size();
        logic [DW-1:0] d0, d1;
        rdt_ready = 1'b0;
        send_cmd(1'b0, 10'h001, 11'd2, ok);
        for (int i = 0; i < 200; i++) begin
            if (rdt_valid_o) begin seen = 1'b1; break; end
            step(1);
        end
        for (int i = 0; i < 20; i++) begin
            if (rdt_valid_o !== 1'b1 || rdt_data_o !== 16'h3030 || mem_rd_o !== 1'b0) stable = 1'b0;
            step(1);
        end
        tests++;
        if ({ok, seen, stable} !== 3'b111) begin fails++; $display("FAIL bp_hold: got acc/seen/stable %b%b%b want 111", ok, seen, stable); end
        tests++;
        if (n_rd_req - r0 !== 1) begin fails++; $display("FAIL bp_no_new_req: got %0d reqs want 1", n_rd_req - r0); end
        rdt_ready = 1'b1;
        wait_done(dok, err);
        d0 = (rbase < rdq.size()) ? rdq[rbase] : 'x;
        d1 = (rbase + 1 < rdq.size()) ? rdq[rbase + 1] : 'x;
        tests++;
        if ({dok, err} !== 2'b10 || d0 !== 16'h3030 || d1 !== 16'h9090 || n_rd_req - r0 !== 2) begin
            fails++; $display("FAIL bp_data: got done/err %b%b words %h %h reqs %0d want 10 3030 9090 2", dok, err, d0, d1, n_rd_req - r0);
        end
    endtask

    task automatic test_range_error;
        bit ok;
        int unsigned w0 = n_wr_req;
        send_cmd(1'b1, 10'h0FE, 11'd4, ok);
        tests++;
        if ({ok, done_o, err_o} !== 3'b111) begin fails++; $display("FAIL range_err: got acc/done/err %b%b%b want 111", ok, done_o, err_o); end
        step(1);
        tests++;
        if (done_o !== 1'b0) begin fails++; $display("FAIL range_pulse: got done %b want 0", done_o); end
        step(4);
        tests++;
        if (n_wr_req - w0 !== 0) begin fails++; $display("FAIL range_no_wr: got %0d writes want 0", n_wr_req - w0); end
        send_cmd(1'b0, 10'h100, 11'd1, ok);
        tests++;
        if ({ok, done_o, err_o} !== 3'b111) begin fails++; $display("FAIL range_addr_n: got %b%b%b want 111", ok, done_o, err_o); end
        step(1);
    endtask

    task automatic test_boundary;
        bit ok, fok, dok;
        logic err;
        wpat[0] = 16'hA1A1; wpat[1] = 16'hB2B2; wpat[2] = 16'hC3C3;
        send_cmd(1'b1, 10'h0FD, 11'd3, ok);
        feed(3, fok);
        wait_done(dok, err);
        tests++;
        if ({ok, fok, dok, err} !== 4'b1110 || mem_arr[255] !== 16'hC3C3) begin
            fails++; $display("FAIL boundary_end: got %b%b%b%b mem[ff]=%h want 1110 c3c3", ok, fok, dok, err, mem_arr[255]);
        end
    endtask

    task automatic test_len_zero;
        bit ok;
        int unsigned r0 = n_rd_req;
        send_cmd(1'b0, 10'h005, 11'd0, ok);
        tests++;
        if ({ok, done_o, err_o} !== 3'b110) begin fails++; $display("FAIL len0_done: got %b%b%b want 110", ok, done_o, err_o); end
        step(3);
        tests++;
        if (n_rd_req - r0 !== 0) begin fails++; $display("FAIL len0_no_req: got %0d want 0", n_rd_req - r0); end
    endtask

    task automatic test_no_wok;
        bit ok, fok, dok;
        logic err;
        int unsigned w0 = n_wr_req;
        no_wok = 1'b1;
        wpat[0] = 16'h5555;
        send_cmd(1'b1, 10'h010, 11'd2, ok);
        feed(1, fok);
        wait_done(dok, err);
        no_wok = 1'b0;
        tests++;
        if ({ok, fok, dok, err} !== 4'b1111 || n_wr_req - w0 !== 1) begin
            fails++; $display("FAIL no_wok: got %b%b%b%b writes %0d want 1111 1", ok, fok, dok, err, n_wr_req - w0);
        end
        step(2);
    endtask

    task automatic test_timeout;
        bit ok;
        int unsigned cyc = 0;
        stuck = 1'b1;
        send_cmd(1'b0, 10'h000, 11'd1, ok);
        while (!done_o && cyc < 500) begin
            step(1);
            cyc++;
        end
        tests++;
        if (ok !== 1'b1 || cyc !== TO || err_o !== 1'b1 || mem_rd_o !== 1'b0) begin
            fails++; $display("FAIL timeout: got acc %b cycles %0d err %b rd %b want 1 %0d 1 0", ok, cyc, err_o, mem_rd_o, TO);
        end
        stuck = 1'b0;
        step(3);
    endtask

    task automatic test_reset_mid_burst;
        bit ok, dok, seen = 1'b0;
        logic err;
        int unsigned d0;
        logic [DW-1:0] last;
        rdt_ready = 1'b0;
        send_cmd(1'b0, 10'h001, 11'd2, ok);
        for (int i = 0; i < 200; i++) begin
            if (rdt_valid_o) begin seen = 1'b1; break; end
            step(1);
        end
        d0 = n_done;
        rst_n = 1'b0;
        #1;
        tests++;
        if (seen !== 1'b1 || outs !== '0) begin fails++; $display("FAIL midrst_outputs: got seen %b outs %h want 1 0", seen, outs); end
        step(3);
        rst_n = 1'b1;
        rdt_ready = 1'b1;
        step(2);
        tests++;
        if (n_done - d0 !== 0) begin fails++; $display("FAIL midrst_no_done: got %0d want 0", n_done - d0); end
        send_cmd(1'b0, 10'h002, 11'd1, ok);
        wait_done(dok, err);
        step(1);
        last = (rdq.size() > 0) ? rdq[rdq.size() - 1] : 'x;
        tests++;
        if ({ok, dok, err} !== 3'b110 || last !== 16'h9090) begin
            fails++; $display("FAIL midrst_next: got %b%b%b data %h want 110 9090", ok, dok, err, last);
        end
    endtask

    task automatic test_exclusive;
        tests++;
        if (n_excl !== 0) begin fails++; $display("FAIL rd_wr_exclusive: got %0d overlaps want 0", n_excl); end
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdt_valid = 1'b0; wdt_data = '0; rdt_ready = 1'b1; stuck = 1'b0; no_wok = 1'b0;
        for (int i = 0; i < 4; i++) wpat[i] = '0;
        #1;
        test_reset;
        test_write_burst;
        test_read_burst;
        test_read_backpressure;
        test_range_error;
        test_boundary;
        test_len_zero;
        test_no_wok;
        test_timeout;
        test_reset_mid_burst;
        test_exclusive;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
